// File: rtl/one_hot_iterator_if.sv
// one_hot_iterator_if: load, beat and control signals shared by one_hot_iterator and its user.
interface one_hot_iterator_if #(parameter int WIDTH = 8);
  localparam int INDEX_WIDTH = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
  logic clear;
  logic load_valid;
  logic [WIDTH-1:0] load_data;
  logic load_ready;
  logic out_valid;
  logic [WIDTH-1:0] out_one_hot;
  logic [INDEX_WIDTH-1:0] out_index;
  logic out_last;
  logic out_ready;
  logic busy;
  modport master (
    output clear, load_valid, load_data, out_ready,
    input load_ready, out_valid, out_one_hot, out_index, out_last, busy
  );
  modport slave (
    input clear, load_valid, load_data, out_ready,
    output load_ready, out_valid, out_one_hot, out_index, out_last, busy
  );
endinterface

// File: rtl/one_hot_iterator.sv
// one_hot_iterator: emits the set bits of a loaded vector as one-hot beats, lowest bit first.
module one_hot_iterator #(
  parameter int WIDTH = 8
) (
  input logic clock,
  input logic reset,
  one_hot_iterator_if.slave bus
);
  localparam int IW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, ITERATE} state_t;
  state_t state;
  logic [WIDTH-1:0] remaining;
  logic [WIDTH-1:0] lowest;
  logic [WIDTH-1:0] rest;
  logic [IW-1:0] index;
  logic iterating;
  logic last;
  logic fire;
  logic load;
  always_comb begin
    lowest = remaining & (~remaining + WIDTH'(1));
    rest = remaining & ~lowest;
    last = rest == '0;
    index = '0;
    for (int i = 0; i < WIDTH; i++)
      if (lowest[i]) index = IW'(i);
  end
  assign iterating = state == ITERATE;
  assign fire = iterating && bus.out_ready;
  // A load may land on the final beat so a new vector follows without a bubble.
  assign bus.load_ready = (!iterating || (fire && last)) && !bus.clear && !reset;
  assign load = bus.load_valid && bus.load_ready;
  assign bus.out_valid = iterating;
  assign bus.busy = iterating;
  assign bus.out_one_hot = iterating ? lowest : '0;
  assign bus.out_index = iterating ? index : '0;
  assign bus.out_last = iterating && last;
  always_ff @(posedge clock) begin
    if (reset || bus.clear) begin
      state <= IDLE;
      remaining <= '0;
    end else if (load) begin
      remaining <= bus.load_data;
      state <= (bus.load_data != '0) ? ITERATE : IDLE;
    end else if (fire) begin
      remaining <= rest;
      state <= last ? IDLE : ITERATE;
    end
  end
endmodule

// File: tb/tb_one_hot_iterator.sv
// tb_one_hot_iterator: directed scenarios plus a per-cycle comparison against a bit-list queue model.
module tb_one_hot_iterator;
  localparam int WIDTH = 8;
  localparam int IW = 3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  one_hot_iterator_if #(.WIDTH(WIDTH)) bus ();
  one_hot_iterator #(.WIDTH(WIDTH)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  // Reference model: queue of the bit positions still to be emitted.
  int q[$];
  int exp_total = 0;
  int beat_cnt = 0;
  bit mon_en = 0;
  always @(posedge clock) begin
    bit rdy;
    rdy = (q.size() == 0 || (bus.out_ready && q.size() == 1)) && !bus.clear && !reset;
    if (reset) mon_en = 1;
    if (reset || bus.clear) q.delete();
    else if (bus.load_valid && rdy) begin
      q.delete();
      for (int i = 0; i < WIDTH; i++) if (bus.load_data[i]) q.push_back(i);
      exp_total = q.size();
    end else if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
  end
  always @(negedge clock) if (mon_en) begin
    logic [WIDTH-1:0] e_oh;
    logic [IW-1:0] e_idx;
    logic e_v, e_last, e_rdy;
    e_v = q.size() != 0;
    e_oh = '0;
    e_idx = '0;
    if (e_v) begin
      e_oh[q[0]] = 1'b1;
      e_idx = IW'(q[0]);
    end
    e_last = q.size() == 1;
    e_rdy = (!e_v || (bus.out_ready && e_last)) && !bus.clear && !reset;
    checks++;
    if ({bus.out_valid, bus.busy, bus.out_one_hot, bus.out_index, bus.out_last, bus.load_ready} !==
        {e_v, e_v, e_oh, e_idx, e_last, e_rdy}) begin
      errors++;
      $display("FAIL monitor t=%0t: got v=%b busy=%b oh=%b idx=%0d last=%b rdy=%b, want v=%b busy=%b oh=%b idx=%0d last=%b rdy=%b",
        $time, bus.out_valid, bus.busy, bus.out_one_hot, bus.out_index, bus.out_last, bus.load_ready,
        e_v, e_v, e_oh, e_idx, e_last, e_rdy);
    end
    if (reset || bus.clear) beat_cnt = 0;
    else if (bus.out_valid && bus.out_ready) begin
      beat_cnt++;
      if (bus.out_last) begin
        checks++;
        if (beat_cnt !== exp_total) begin
          errors++;
          $display("FAIL beat_count: got %0d beats, want %0d", beat_cnt, exp_total);
        end
        beat_cnt = 0;
      end
    end
  end
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    checks++;
    if (bus.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", bus.load_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.busy, bus.out_one_hot, bus.out_index, bus.out_last, bus.load_ready} !== {2'b00, 8'h00, 3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b busy=%b oh=%b idx=%0d last=%b rdy=%b want all 0, rdy=1",
        bus.out_valid, bus.busy, bus.out_one_hot, bus.out_index, bus.out_last, bus.load_ready);
    end
    cyc();
  endtask
  task automatic test_basic();
    logic [WIDTH-1:0] oh [4] = '{8'h02, 8'h04, 8'h20, 8'h80};
    logic [IW-1:0] ix [4] = '{3'd1, 3'd2, 3'd5, 3'd7};
    bus.out_ready = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 8'b1010_0110;
    cyc();
    bus.load_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({bus.busy, bus.out_one_hot, bus.out_index, bus.out_last} !== {1'b1, oh[k], ix[k], k == 3}) begin
        errors++;
        $display("FAIL basic_beat%0d: got busy=%b oh=%b idx=%0d last=%b want busy=1 oh=%b idx=%0d last=%b",
          k, bus.busy, bus.out_one_hot, bus.out_index, bus.out_last, oh[k], ix[k], k == 3);
      end
      cyc();
    end
    checks++;
    if ({bus.busy, bus.out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL basic_done: got busy=%b v=%b want 0 0", bus.busy, bus.out_valid);
    end
  endtask
  task automatic test_zero();
    bus.out_ready = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 8'h00;
    #1;
    checks++;
    if (bus.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready: got %b want 1", bus.load_ready);
    end
    cyc();
    bus.load_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({bus.out_valid, bus.busy, bus.load_ready} !== 3'b001) begin
        errors++;
        $display("FAIL zero_idle%0d: got v=%b busy=%b rdy=%b want 0 0 1", k, bus.out_valid, bus.busy, bus.load_ready);
      end
      cyc();
    end
  endtask
  task automatic test_stall();
    bus.out_ready = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data = 8'h81;
    cyc();
    bus.load_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.out_ready = (k == 3);
      #1;
      checks++;
      if ({bus.out_valid, bus.out_one_hot, bus.out_index, bus.out_last} !== {1'b1, 8'h01, 3'd0, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b oh=%b idx=%0d last=%b want 1 00000001 0 0",
          k, bus.out_valid, bus.out_one_hot, bus.out_index, bus.out_last);
      end
      cyc();
    end
    #1;
    checks++;
    if ({bus.out_valid, bus.out_one_hot, bus.out_index, bus.out_last} !== {1'b1, 8'h80, 3'd7, 1'b1}) begin
      errors++;
      $display("FAIL stall_last: got v=%b oh=%b idx=%0d last=%b want 1 10000000 7 1",
        bus.out_valid, bus.out_one_hot, bus.out_index, bus.out_last);
    end
    cyc();
  endtask
  task automatic test_back_to_back();
    logic [WIDTH-1:0] one;
    bus.out_ready = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 8'hFF;
    cyc();
    bus.load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      one = 8'h01 << k;
      if (k == 7) begin
        bus.load_valid = 1'b1;
        bus.load_data = 8'h10;
      end
      #1;
      checks++;
      if ({bus.out_one_hot, bus.out_index, bus.out_last, bus.load_ready} !== {one, IW'(k), k == 7, k == 7}) begin
        errors++;
        $display("FAIL b2b_beat%0d: got oh=%b idx=%0d last=%b rdy=%b want oh=%b idx=%0d last=%b rdy=%b",
          k, bus.out_one_hot, bus.out_index, bus.out_last, bus.load_ready, one, k, k == 7, k == 7);
      end
      cyc();
      bus.load_valid = 1'b0;
    end
    #1;
    checks++;
    if ({bus.out_valid, bus.out_one_hot, bus.out_index, bus.out_last} !== {1'b1, 8'h10, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL b2b_next: got v=%b oh=%b idx=%0d last=%b want 1 00010000 4 1",
        bus.out_valid, bus.out_one_hot, bus.out_index, bus.out_last);
    end
    cyc();
  endtask
  task automatic test_clear();
    bus.out_ready = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 8'hF0;
    cyc();
    bus.load_valid = 1'b0;
    cyc();
    bus.clear = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 8'h01;
    #1;
    checks++;
    if ({bus.load_ready, bus.out_one_hot} !== {1'b0, 8'h20}) begin
      errors++;
      $display("FAIL clear_cycle: got rdy=%b oh=%b want 0 00100000", bus.load_ready, bus.out_one_hot);
    end
    cyc();
    bus.clear = 1'b0;
    bus.load_valid = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.busy, bus.out_one_hot, dut.remaining} !== {2'b00, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL clear_after: got v=%b busy=%b oh=%b remaining=%b want 0 0 0 0",
        bus.out_valid, bus.busy, bus.out_one_hot, dut.remaining);
    end
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_noload: got v=%b want 0", bus.out_valid);
    end
  endtask
  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 8'hFF;
    cyc();
    bus.load_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data = 8'h03;
    #1;
    checks++;
    if (bus.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready: got %b want 0", bus.load_ready);
    end
    cyc();
    reset = 1'b0;
    bus.load_valid = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.busy, bus.load_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_after: got v=%b busy=%b rdy=%b want 0 0 1", bus.out_valid, bus.busy, bus.load_ready);
    end
    bus.load_valid = 1'b1;
    bus.load_data = 8'h02;
    cyc();
    bus.load_valid = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_one_hot, bus.out_index, bus.out_last} !== {1'b1, 8'h02, 3'd1, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_beat: got v=%b oh=%b idx=%0d last=%b want 1 00000010 1 1",
        bus.out_valid, bus.out_one_hot, bus.out_index, bus.out_last);
    end
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_done: got v=%b want 0", bus.out_valid);
    end
  endtask
  task automatic test_exhaustive();
    bit acc;
    for (int v = 0; v < 256; v++) begin
      bus.load_valid = 1'b1;
      bus.load_data = 8'(v);
      acc = 0;
      for (int n = 0; n < 64 && !acc; n++) begin
        bus.out_ready = $urandom_range(0, 3) != 0;
        bus.clear = $urandom_range(0, 47) == 0;
        #1;
        acc = bus.load_ready;
        cyc();
      end
      bus.clear = 1'b0;
      checks++;
      if (!acc) begin
        errors++;
        $display("FAIL exh_accept: value %0d not accepted within 64 cycles", v);
      end
    end
    bus.load_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 20 && bus.busy; n++) cyc();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL exh_drain: got busy=%b want 0", bus.busy);
    end
  endtask
  initial begin
    bus.clear = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_stall();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_exhaustive();
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/one_hot_iterator.md
ONE_HOT_ITERATOR -- requirements
Module: one_hot_iterator

Interface
REQ-001 Parameter: WIDTH, default 8, width of the loaded bit vector; legal range 2 or greater.
REQ-002 Derived constant: INDEX_WIDTH = max(1, $clog2(WIDTH)).
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clear  input  1  synchronous abort of the current iteration.
REQ-006 load_valid  input  1  load_data is offered.
REQ-007 load_data  input  WIDTH  bit vector to iterate over.
REQ-008 load_ready  output  1  the block accepts a load this cycle.
REQ-009 out_valid  output  1  a one-hot beat is offered.
REQ-010 out_one_hot  output  WIDTH  lowest remaining set bit, one-hot.
REQ-011 out_index  output  INDEX_WIDTH  binary position of out_one_hot.
REQ-012 out_last  output  1  the current beat is the final set bit of the vector.
REQ-013 out_ready  input  1  the consumer takes the beat this cycle.
REQ-014 busy  output  1  the block is in the ITERATE state.

Function
REQ-015 The block SHALL hold a WIDTH-bit remaining register and a two-state FSM with states IDLE and ITERATE.
REQ-016 A load SHALL be accepted when load_valid and load_ready are both 1.
REQ-017 A beat SHALL be transferred when out_valid and out_ready are both 1.
REQ-018 load_ready SHALL equal (state==IDLE or beat transferred with out_last=1) and not clear and not reset; this is a combinational path from out_ready.
REQ-019 Accepting a load with a non-zero value SHALL load remaining with load_data and move the FSM to ITERATE on the next edge.
REQ-020 Accepting a load with load_data==0 SHALL be consumed silently: the FSM goes to or stays in IDLE and no beat is produced.
REQ-021 out_valid SHALL be 1 exactly when state==ITERATE; the first beat appears the cycle after the load is accepted (latency 1).
REQ-022 out_one_hot SHALL be the lowest set bit of remaining, as given by remaining & (~remaining + 1).
REQ-023 out_one_hot, out_index and out_last SHALL be all-zero whenever out_valid=0.
REQ-024 out_index SHALL be the binary encoding of out_one_hot.
REQ-025 out_last SHALL be 1 exactly when remaining & ~out_one_hot == 0.
REQ-026 On a transferred beat, remaining SHALL update to remaining & ~out_one_hot.
REQ-027 On a transferred beat with out_last=1, the FSM SHALL go to IDLE.
REQ-028 If a load is accepted in the same cycle as the last beat, the new vector SHALL take effect instead (back-to-back operation with no bubble).
REQ-029 While out_valid=1 and out_ready=0, out_one_hot, out_index and out_last SHALL hold stable.
REQ-030 A vector with N set bits SHALL produce exactly N beats, in ascending bit order.
REQ-031 clear=1 SHALL, on the next edge, set remaining to 0 and the FSM to IDLE.
REQ-032 clear SHALL take priority over a simultaneous load or beat transfer; the load is not accepted and load_ready is 0 in that cycle.
REQ-033 clear asserted in IDLE SHALL have no effect beyond forcing load_ready=0 for that cycle.
REQ-034 Loads SHALL be ignored while in ITERATE, except as allowed by REQ-028.
REQ-035 All-ones input SHALL produce WIDTH beats; a single bit at position WIDTH-1 SHALL produce one beat with out_index=WIDTH-1 and out_last=1.

Reset
REQ-036 While reset=1, load_ready SHALL be 0.
REQ-037 On the edge with reset=1, the FSM SHALL go to IDLE and remaining SHALL clear to 0.
REQ-038 From the cycle after reset deasserts, out_valid, out_one_hot, out_index, out_last and busy SHALL be 0 and load_ready SHALL be 1.
REQ-039 reset SHALL override clear, load and beat transfer, including in the middle of an iteration.

Verification
REQ-040 With WIDTH=8, the bench SHALL cover the following directed scenarios.
REQ-041 Load 8'b1010_0110 with out_ready=1 -> beats 00000010/idx1, 00000100/idx2, 00100000/idx5, 10000000/idx7, last on the 4th beat only, busy for 4 cycles.
REQ-042 Load 8'h00 -> no beat produced, load_ready stays 1, busy stays 0.
REQ-043 Load 8'h81, out_ready=0 for 3 cycles, then 1 -> beat 00000001/idx0 held stable for 4 cycles, then 10000000/idx7 with last=1.
REQ-044 Load 8'hFF, then load 8'h10 in the cycle of the 8th (last) beat -> 8 ascending beats, immediately followed by 00010000/idx4 with last=1 and no idle cycle in between.
REQ-045 Load 8'hF0, transfer 1 beat, then assert clear together with load_valid carrying 8'h01 -> next cycle is IDLE with out_valid=0, the 8'h01 load is not accepted, and remaining=0.
REQ-046 Assert reset in the middle of an 8'hFF iteration -> the cycle after reset: out_valid=0, load_ready=1; a new load of 8'h02 produces a single beat idx1 with last=1.
REQ-047 In every cycle the bench SHALL check the out_one_hot/out_index/out_last relation and the total beat count against an exhaustive reference model over all 256 values.
